// File: rtl/sa_pkg.sv
// ============================================================================
//  Module : sa_pkg
//  Shared widths, array defaults and FSM encodings for the systolic datapath.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sa_pkg;

    localparam int INPUT_WIDTH  = 8;
    localparam int WEIGHT_WIDTH = 8;
    localparam int PSUM_WIDTH   = 32;
    localparam int ARRAY_HEIGHT = 4;
    localparam int ARRAY_WIDTH  = 4;
    localparam int ACC_WIDTH    = 40;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_ACCUM = 2'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;

endpackage

`default_nettype wire

// File: rtl/psum_lane_acc.sv
// ============================================================================
//  Module : psum_lane_acc
//  One lane: sign-extend psum, then load it or add it to the stored value.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module psum_lane_acc #(
    parameter int PSUM_WIDTH = 32,
    parameter int ACC_WIDTH  = 40
) (
    input  logic [PSUM_WIDTH-1:0] psum_i,
    input  logic [ACC_WIDTH-1:0]  acc_i,
    input  logic                  load_i,
    output logic [ACC_WIDTH-1:0]  sum_o,
    output logic                  ovf_o
);

    logic [ACC_WIDTH-1:0] ext_w;
    logic [ACC_WIDTH-1:0] add_w;

    assign ext_w = ACC_WIDTH'($signed(psum_i));
    assign add_w = acc_i + ext_w;
    assign sum_o = load_i ? ext_w : add_w;

    // Signed overflow: operands agree in sign but the wrapped result does not.
    assign ovf_o = !load_i && (acc_i[ACC_WIDTH-1] == ext_w[ACC_WIDTH-1])
                           && (add_w[ACC_WIDTH-1] != acc_i[ACC_WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/psum_accum_buffer.sv
// ============================================================================
//  Module : psum_accum_buffer
//  Accumulates psum rows over several K passes, then drains the tile as a stream.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module psum_accum_buffer
    import sa_pkg::*;
#(
    parameter int PSUM_WIDTH  = 32,
    parameter int ARRAY_WIDTH = 4,
    parameter int DEPTH       = 4,
    parameter int ACC_WIDTH   = 40,
    parameter int PASS_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [PASS_WIDTH-1:0]             cfg_num_passes,
    input  logic                              psum_valid,
    input  logic [ARRAY_WIDTH*PSUM_WIDTH-1:0] psum_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ARRAY_WIDTH*ACC_WIDTH-1:0]  out_data,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done,
    output logic                              overflow,
    output logic                              drop_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ROW_W = ARRAY_WIDTH * ACC_WIDTH;
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(DEPTH - 1);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PASS_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
    logic [PASS_WIDTH-1:0] passes_q, passes_d;
    logic                  done_q, overflow_q, overflow_d, drop_err_q, drop_err_d;
    logic [ROW_W-1:0]      mem_q [DEPTH];

    logic                  start_acc, beat, final_beat, hs, hs_last;
    logic [ROW_W-1:0]      row_sum;
    logic [ARRAY_WIDTH-1:0] lane_ovf;

    generate
        for (genvar i = 0; i < ARRAY_WIDTH; i++) begin : g_lane
            psum_lane_acc #(
                .PSUM_WIDTH (PSUM_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_lane (
                .psum_i (psum_in[i*PSUM_WIDTH +: PSUM_WIDTH]),
                .acc_i  (mem_q[wr_ptr_q][i*ACC_WIDTH +: ACC_WIDTH]),
                .load_i (pass_cnt_q == '0),
                .sum_o  (row_sum[i*ACC_WIDTH +: ACC_WIDTH]),
                .ovf_o  (lane_ovf[i])
            );
        end
    endgenerate

    always_comb begin
        start_acc  = (state_q == ST_IDLE) && start;
        beat       = (state_q == ST_ACCUM) && psum_valid;
        final_beat = beat && (wr_ptr_q == LAST_ROW)
                          && (pass_cnt_q == passes_q - PASS_WIDTH'(1));
        hs         = (state_q == ST_DRAIN) && out_ready;
        hs_last    = hs && (rd_ptr_q == LAST_ROW);

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pass_cnt_d = pass_cnt_q;
        passes_d   = passes_q;
        overflow_d = overflow_q;
        drop_err_d = drop_err_q | (psum_valid && (state_q != ST_ACCUM));

        if (start_acc) begin
            state_d    = ST_ACCUM;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pass_cnt_d = '0;
            passes_d   = (cfg_num_passes == '0) ? PASS_WIDTH'(1) : cfg_num_passes;
            overflow_d = 1'b0;
            // A beat coinciding with start is dropped, so it re-flags the fresh error.
            drop_err_d = psum_valid;
        end

        if (beat) begin
            overflow_d = overflow_q | (|lane_ovf);
            if (wr_ptr_q == LAST_ROW) begin
                wr_ptr_d   = '0;
                pass_cnt_d = pass_cnt_q + PASS_WIDTH'(1);
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (final_beat) begin
                state_d = ST_DRAIN;
            end
        end

        if (hs) begin
            rd_ptr_d = hs_last ? '0 : rd_ptr_q + PTR_W'(1);
            if (hs_last) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pass_cnt_q <= '0;
            passes_q   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_err_q <= 1'b0;
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pass_cnt_q <= pass_cnt_d;
            passes_q   <= passes_d;
            done_q     <= hs_last;
            overflow_q <= overflow_d;
            drop_err_q <= drop_err_d;
            if (beat) begin
                mem_q[wr_ptr_q] <= row_sum;
            end
        end
    end

    assign out_valid = (state_q == ST_DRAIN);
    assign out_data  = mem_q[rd_ptr_q];
    assign out_last  = out_valid && (rd_ptr_q == LAST_ROW);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign drop_err  = drop_err_q;

endmodule

`default_nettype wire

// File: tb/tb_psum_accum_buffer.sv
// ============================================================================
//  Module : tb_psum_accum_buffer
//  Directed checks of accumulation, drain back-pressure, overflow and error flags.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_psum_accum_buffer;

    localparam int PW  = 32;
    localparam int AW  = 4;
    localparam int D   = 4;
    localparam int ACW = 40;
    localparam int PAW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              start, psum_valid, out_ready;
    logic [PAW-1:0]    cfg_num_passes;
    logic [AW*PW-1:0]  psum_in;
    logic              out_valid, out_last, busy, done, overflow, drop_err;
    logic [AW*ACW-1:0] out_data;

    logic              o_start, o_valid, o_ready;
    logic [PAW-1:0]    o_cfg;
    logic [AW*PW-1:0]  o_psum;
    logic              o_out_valid, o_last, o_busy, o_done, o_ovf, o_drop;
    logic [AW*33-1:0]  o_data;

    psum_accum_buffer #(.PSUM_WIDTH(PW), .ARRAY_WIDTH(AW), .DEPTH(D),
                        .ACC_WIDTH(ACW), .PASS_WIDTH(PAW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_passes(cfg_num_passes),
        .psum_valid(psum_valid), .psum_in(psum_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .overflow(overflow), .drop_err(drop_err)
    );

    psum_accum_buffer #(.PSUM_WIDTH(PW), .ARRAY_WIDTH(AW), .DEPTH(1),
                        .ACC_WIDTH(33), .PASS_WIDTH(PAW)) dut_ov (
        .clk(clk), .rst(rst), .start(o_start), .cfg_num_passes(o_cfg),
        .psum_valid(o_valid), .psum_in(o_psum), .out_valid(o_out_valid),
        .out_ready(o_ready), .out_data(o_data), .out_last(o_last),
        .busy(o_busy), .done(o_done), .overflow(o_ovf), .drop_err(o_drop)
    );

    typedef struct {
        logic [AW*PW-1:0]  psum;
        logic [AW*ACW-1:0] exp1;
        logic [AW*ACW-1:0] exp2;
    } vec_t;

    vec_t vecs [D];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [AW*PW-1:0] prow(int a, int b, int c, int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [AW*ACW-1:0] arow(longint a, longint b, longint c, longint d);
        return {40'(d), 40'(c), 40'(b), 40'(a)};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Feed the stored rows `passes` times, then drain with optional back-pressure.
    task automatic run_tile(input int cfg, input int passes, input int sel,
                            input bit stall_pat, input bit start_in_drain);
        bit [6:0] pat = 7'b1101001;   // bit k = ready on drain cycle k: 1,0,0,1,0,1,1
        int idx = 0;
        int cyc = 0;
        bit prev_stall = 0;
        logic [AW*ACW-1:0] prev_data = '0;
        @(negedge clk);
        start = 1'b1;
        cfg_num_passes = PAW'(cfg);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("drop_clear_on_start", drop_err, 1'b0);
        for (int p = 0; p < passes; p++) begin
            for (int r = 0; r < D; r++) begin
                psum_valid = 1'b1;
                psum_in    = vecs[r].psum;
                @(negedge clk);
            end
        end
        psum_valid = 1'b0;
        psum_in    = '0;
        chk("out_valid_rise", out_valid, 1'b1);
        while (idx < D && cyc < 60) begin
            out_ready = stall_pat ? ((cyc < 7) ? pat[cyc] : 1'b1) : 1'b1;
            start     = start_in_drain && (cyc == 0);
            if (prev_stall) chk("hold_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
                chk($sformatf("row%0d_data", idx), out_data,
                    (sel == 1) ? vecs[idx].exp1 : vecs[idx].exp2);
                chk($sformatf("row%0d_last", idx), out_last, idx == D - 1);
                idx++;
                prev_stall = 0;
            end else begin
                prev_stall = out_valid;
                prev_data  = out_data;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        start     = 1'b0;
        chk("handshake_count", 160'(idx), 160'(D));
        chk("done_pulse", done, 1'b1);
        chk("idle_after_drain", busy, 1'b0);
        chk("valid_low_after_drain", out_valid, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("still_idle", busy, 1'b0);
    endtask

    task automatic run_ov(input int passes, input logic [32:0] e0, input logic [32:0] e1,
                          input logic e_ovf);
        @(negedge clk);
        o_start = 1'b1;
        o_cfg   = PAW'(passes);
        @(negedge clk);
        o_start = 1'b0;
        for (int p = 0; p < passes; p++) begin
            o_valid = 1'b1;
            o_psum  = prow(32'h7FFFFFFF, -5, 0, 0);
            @(negedge clk);
        end
        o_valid = 1'b0;
        chk("ov_valid", o_out_valid, 1'b1);
        chk("ov_last", o_last, 1'b1);
        chk($sformatf("ov_lane0_p%0d", passes), o_data[32:0], e0);
        chk($sformatf("ov_lane1_p%0d", passes), o_data[65:33], e1);
        chk($sformatf("ov_flag_p%0d", passes), o_ovf, e_ovf);
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        chk("ov_done", o_done, 1'b1);
    endtask

    initial begin
        vecs[0] = '{prow( 90, 100, 110, 120), arow( 90, 100, 110, 120), arow(180, 200, 220, 240)};
        vecs[1] = '{prow(202, 228, 254, 280), arow(202, 228, 254, 280), arow(404, 456, 508, 560)};
        vecs[2] = '{prow(314, 356, 398, 440), arow(314, 356, 398, 440), arow(628, 712, 796, 880)};
        vecs[3] = '{prow(426, 484, 542, 600), arow(426, 484, 542, 600), arow(852, 968, 1084, 1200)};

        rst = 1'b1;
        start = 0; cfg_num_passes = '0; psum_valid = 0; psum_in = '0; out_ready = 0;
        o_start = 0; o_cfg = '0; o_valid = 0; o_psum = '0; o_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, '0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_flags", {overflow, drop_err}, 2'b00);
        rst = 1'b0;

        run_tile(1, 1, 1, 1'b0, 1'b0);
        chk("no_ovf_p1", overflow, 1'b0);
        chk("no_drop_p1", drop_err, 1'b0);
        run_tile(2, 2, 2, 1'b0, 1'b0);
        run_tile(1, 1, 1, 1'b1, 1'b0);
        run_tile(0, 1, 1, 1'b0, 1'b0);

        run_ov(1, 33'h07FFFFFFF, 33'h1FFFFFFFB, 1'b0);
        run_ov(2, 33'h0FFFFFFFE, 33'h1FFFFFFF6, 1'b0);
        run_ov(3, 33'h17FFFFFFD, 33'h1FFFFFFF1, 1'b1);

        // Reset midway through a tile discards it.
        @(negedge clk);
        start = 1'b1; cfg_num_passes = 8'd1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            psum_valid = 1'b1; psum_in = vecs[r].psum;
            @(negedge clk);
        end
        psum_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_buf0", out_data, '0);
        @(negedge clk);
        rst = 1'b0;
        run_tile(1, 1, 1, 1'b0, 1'b0);

        // Stray beat in IDLE, then a start request while draining.
        psum_valid = 1'b1; psum_in = vecs[0].psum;
        @(negedge clk);
        psum_valid = 1'b0;
        chk("idle_beat_drop", drop_err, 1'b1);
        chk("idle_beat_nostate", busy, 1'b0);
        run_tile(1, 1, 1, 1'b0, 1'b1);
        chk("drain_start_nodrop", drop_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
